// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared encodings for the iterative multiply/divide unit.
//   opE    : request opcode presented on muldiv_unit.op
//   stateE : sequencer state of muldiv_unit
// Helper functions decode the opcode bits so every file agrees on
// which ops are signed and which are divides.
// Optional feature macro: MULDIV_DIV_EN (enables DIV/DIVU).
package muldiv_pkg;

  // Bit 1 selects divide, bit 0 selects the unsigned variant.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } opE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } stateE;

  function automatic logic opIsSigned(input logic [1:0] opCode);
    return (opCode == OP_MULT) || (opCode == OP_DIV);
  endfunction

  function automatic logic opIsDiv(input logic [1:0] opCode);
    return (opCode == OP_DIV) || (opCode == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// Combinational single radix-2 iteration of the multiply/divide datapath.
// The 2*XLEN accumulator is shared by both operations:
//   multiply : {partial product high half, remaining multiplier bits}
//   divide   : {partial remainder, dividend bits shifting into quotient}
// Ports:
//   accIn   in  2*XLEN  accumulator before the step
//   operand in  XLEN    multiplicand magnitude or divisor magnitude
//   isDiv   in  1       select divide step (only when MULDIV_DIV_EN)
//   accOut  out 2*XLEN  accumulator after the step
// Optional feature macro: MULDIV_DIV_EN (adds the shift-subtract path).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] accIn,
  input  logic [XLEN-1:0]   operand,
`ifdef MULDIV_DIV_EN
  input  logic              isDiv,
`endif
  output logic [2*XLEN-1:0] accOut
);

  logic [XLEN:0]     addSum;
  logic [2*XLEN-1:0] mulOut;

  // Shift-add: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right; the carry lands in the MSB.
  assign addSum = {1'b0, accIn[2*XLEN-1:XLEN]}
                + (accIn[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
  assign mulOut = {addSum, accIn[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     shifted;
  logic [XLEN+1:0]   diff;
  logic              borrow;
  logic [XLEN-1:0]   remNext;
  logic [2*XLEN-1:0] divOut;
  logic              unusedDiffBit;

  // Restoring divide: bring the next dividend bit into the remainder and
  // keep the difference only when it did not go negative.
  assign shifted = {accIn[2*XLEN-1:XLEN], accIn[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, operand};
  assign borrow  = diff[XLEN+1];
  assign remNext = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign divOut  = {remNext, accIn[XLEN-2:0], ~borrow};
  // The kept difference is always below the divisor, so this bit is zero
  // whenever it would matter.
  assign unusedDiffBit = diff[XLEN];

  assign accOut = isDiv ? divOut : mulOut;
`else
  assign accOut = mulOut;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 step per cycle on operand magnitudes; sign correction is
// applied in a final FIX cycle. Latency is XLEN+1 cycles from acceptance.
// Ports:
//   clk          in  1     clock, rising edge
//   rst_n        in  1     synchronous active-low reset
//   start        in  1     request valid
//   op           in  2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         in  XLEN  operands (rs, rt), sampled on acceptance
//   flush        in  1     abort in-flight operation, blocks a new start
//   hi_we, lo_we in  1     mthi/mtlo write strobes (honoured only when idle)
//   wdata        in  XLEN  mthi/mtlo data
//   busy         out 1     operation in progress (RUN or FIX)
//   done         out 1     one-cycle pulse after HI/LO were written by an op
//   hi, lo       out XLEN  HI/LO register contents
// Optional feature macro: MULDIV_DIV_EN. When undefined the divide
// hardware is omitted and ops 10/11 are ignored.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  stateE             state;
  stateE             stateNext;
  logic              accept;
  logic              opLegal;
  logic              fixWrite;
  logic [CNT_W-1:0]  cnt;
  logic              busyQ;
  logic              doneQ;
  logic [XLEN-1:0]   hiQ;
  logic [XLEN-1:0]   loQ;

  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] accStep;
  logic [XLEN-1:0]   operandB;
  logic              signDiff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   hiRes;
  logic [XLEN-1:0]   loRes;

`ifdef MULDIV_DIV_EN
  logic              signA;
  logic              isDivQ;
  logic              divZero;
`endif

  // Absolute value for signed ops; MIN maps to itself, which is the
  // correct unsigned magnitude 2^(XLEN-1).
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic isSigned);
    logic signed [XLEN-1:0] sv;
    sv = v;
    return (isSigned && sv[XLEN-1]) ? XLEN'(-sv) : v;
  endfunction

  function automatic logic [XLEN-1:0] condNeg(input logic [XLEN-1:0] v,
                                              input logic neg);
    return neg ? XLEN'(-v) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] condNegWide(input logic [2*XLEN-1:0] v,
                                                    input logic neg);
    return neg ? (2*XLEN)'(-v) : v;
  endfunction

`ifdef MULDIV_DIV_EN
  assign opLegal = 1'b1;
`else
  assign opLegal = !opIsDiv(op);
`endif

  assign fixWrite = (state == ST_FIX) && !flush;

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !flush && opLegal) begin
          stateNext = ST_RUN;
          accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          stateNext = ST_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          stateNext = ST_FIX;
        end
      end
      ST_FIX: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Control and architectural state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
      cnt   <= '0;
      hiQ   <= '0;
      loQ   <= '0;
    end else begin
      state <= stateNext;
      busyQ <= (stateNext != ST_IDLE);
      doneQ <= fixWrite;
      if (accept) begin
        cnt <= CNT_W'(XLEN);
      end else if (state == ST_RUN) begin
        cnt <= cnt - 1'b1;
      end
      if (fixWrite) begin
        hiQ <= hiRes;
        loQ <= loRes;
      end else if (state == ST_IDLE) begin
        if (hi_we) hiQ <= wdata;
        if (lo_we) loQ <= wdata;
      end
    end
  end

  // Operand capture: multiply and divide load the accumulator identically
  // (upper half zero, lower half |a|), so no op-dependent mux is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc      <= {{XLEN{1'b0}}, magnitude(a, opIsSigned(op))};
      operandB <= magnitude(b, opIsSigned(op));
      signDiff <= opIsSigned(op) && (a[XLEN-1] ^ b[XLEN-1]);
`ifdef MULDIV_DIV_EN
      signA    <= opIsSigned(op) && a[XLEN-1];
      isDivQ   <= opIsDiv(op);
      divZero  <= (b == '0);
`endif
    end else if (state == ST_RUN) begin
      acc <= accStep;
    end
  end

  muldiv_step #(
    .XLEN(XLEN)
  ) uStep (
    .accIn  (acc),
    .operand(operandB),
`ifdef MULDIV_DIV_EN
    .isDiv  (isDivQ),
`endif
    .accOut (accStep)
  );

  // Sign correction evaluated during FIX.
  always_comb begin
    prod  = condNegWide(acc, signDiff);
    hiRes = prod[2*XLEN-1:XLEN];
    loRes = prod[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    if (isDivQ) begin
      // With b=0 the remainder equals |a|; re-applying the sign of a
      // returns a unmodified.
      hiRes = condNeg(acc[2*XLEN-1:XLEN], signA);
      loRes = divZero ? {XLEN{1'b1}} : condNeg(acc[XLEN-1:0], signDiff);
    end
`endif
  end

  assign busy = busyQ;
  assign done = doneQ;
  assign hi   = hiQ;
  assign lo   = loQ;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              flush;
  logic              hi_we;
  logic              lo_we;
  logic [XLEN-1:0]   wdata;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } expT;

  expT sb[$];
  expT monE;
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference results from native 64-bit arithmetic.
  function automatic logic [63:0] modelOp(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx;
    longint sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   r = 64'(sx * sy);
      2'b01:   r = {32'd0, x} * {32'd0, y};
      2'b10:   r = (y == 0) ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
      default: r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    endcase
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending op.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checkVal("unexpected done", 64'(done), 64'd0);
      end else begin
        monE = sb.pop_front();
        checkVal({monE.tag, " hi"}, 64'(hi), 64'(monE.hi));
        checkVal({monE.tag, " lo"}, 64'(lo), 64'(monE.lo));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] expRes);
    int  busyCycles;
    expT e;
    busyCycles = 0;
    e.tag = tag;
    e.hi  = expRes[63:32];
    e.lo  = expRes[31:0];
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCycles++;
      else break;
    end
    checkVal({tag, " busy cycles"}, 64'(busyCycles), 64'd33);
  endtask

  task automatic preload(input logic [31:0] hv, input logic [31:0] lv);
    hi_we = 1'b1;
    wdata = hv;
    @(posedge clk);
    #1 hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = lv;
    @(posedge clk);
    #1 lo_we = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("reset busy", 64'(busy), 64'd0);
    checkVal("reset done", 64'(done), 64'd0);
    checkVal("reset hi", 64'(hi), 64'd0);
    checkVal("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runOp("mult -3*5", 2'b00, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    runOp("multu max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    runOp("mult min*min", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    runOp("mult min*-1", 2'b00, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
`ifdef MULDIV_DIV_EN
    runOp("divu 100/7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
    runOp("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    runOp("div 5/0", 2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    runOp("div -5/0", 2'b10, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF});
    runOp("divu big/0", 2'b11, 32'hF0000001, 32'd0, {32'hF0000001, 32'hFFFFFFFF});
    runOp("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
    runOp("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
`endif
    for (int i = 0; i < 12; i++) begin
`ifdef MULDIV_DIV_EN
      ro = 2'($urandom_range(0, 3));
`else
      ro = 2'($urandom_range(0, 1));
`endif
      rx = $urandom;
      ry = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 3 == 0) ry = ry >> $urandom_range(8, 28);
      runOp("random op", ro, rx, ry, modelOp(ro, rx, ry));
    end

    // Flush mid-run, with an ignored start and mthi/mtlo during the run.
    preload(32'h1234, 32'h5678);
    checkVal("mthi value", 64'(hi), 64'h1234);
    checkVal("mtlo value", 64'(lo), 64'h5678);
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk);
    #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checkVal("busy during run", 64'(busy), 64'd1);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkVal("flush busy", 64'(busy), 64'd0);
    checkVal("flush done", 64'(done), 64'd0);
    checkVal("flush hi kept", 64'(hi), 64'h1234);
    checkVal("flush lo kept", 64'(lo), 64'h5678);
    repeat (40) @(posedge clk);
    #1 checkVal("post flush hi", 64'(hi), 64'h1234);
    checkVal("post flush lo", 64'(lo), 64'h5678);

    // Flush blocks a start presented in the same cycle.
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    checkVal("flush blocks start", 64'(busy), 64'd0);

    // Reset in the middle of a run.
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 checkVal("midrun reset busy", 64'(busy), 64'd0);
    checkVal("midrun reset hi", 64'(hi), 64'd0);
    checkVal("midrun reset lo", 64'(lo), 64'd0);
    checkVal("midrun reset done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 checkVal("after reset busy", 64'(busy), 64'd0);

`ifndef MULDIV_DIV_EN
    // Divide ops are illegal in this build.
    preload(32'hAAAA, 32'hBBBB);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    checkVal("illegal divu busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);
    #1 checkVal("illegal divu hi", 64'(hi), 64'hAAAA);
    checkVal("illegal divu lo", 64'(lo), 64'hBBBB);
`endif

    repeat (3) @(posedge clk);
    #1 checkVal("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the five-stage pipeline. It accepts a MULT/MULTU/DIV/DIVU request from the execute stage and computes it over XLEN+1 cycles. While the operation runs it raises `busy`, so the hazard unit can stall any mfhi/mflo or new mul/div in decode. It also services mthi/mtlo writes and exposes HI/LO for forwarding.

## Interface
- `XLEN`, 32: operand/HI/LO width; must be ≥ 4.
- `CNT_W`, $clog2(XLEN)+1: iteration counter width (derived, not overridden).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request valid this cycle.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, `b` in XLEN: operands (rs, rt), sampled when a start is accepted.
- `flush` in 1: abort any in-flight operation.
- `hi_we`, `lo_we` in 1: mthi/mtlo write strobes.
- `wdata` in XLEN: mthi/mtlo data.
- `busy` out 1: high in RUN and FIX.
- `done` out 1: one-cycle pulse when HI/LO have just been updated by an operation.
- `hi`, `lo` out XLEN: architectural HI/LO register contents.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN on an accepted start. A start is accepted when the state is IDLE, `flush`=0 and the op is legal. On acceptance:
  - operand magnitudes are latched (signed ops take abs; unsigned ops take raw values);
  - sign flags are recorded;
  - counter is loaded with XLEN.
- RUN performs one radix-2 step per cycle and decrements the counter.
  - Multiply: shift-add on a 2·XLEN accumulator.
  - Divide: restoring shift-subtract giving a quotient and remainder.
  - RUN → FIX when the counter reaches 1, after XLEN steps in total.
- FIX applies sign correction and writes HI/LO, then returns to IDLE with `done`=1 for the following cycle.
  - Signed multiply: negate the 2·XLEN product when sign(a)≠sign(b).
  - Signed divide: negate the quotient when the signs differ; the remainder takes the sign of a.
  - HI receives the upper product half or the remainder; LO receives the lower product half or the quotient.
- Divide by zero (b=0) is detected at acceptance and runs the full latency. Result: LO = all ones, HI = a unmodified, no sign correction.
- Signed MIN / −1 gives LO = MIN, HI = 0; this falls out of the magnitude algorithm naturally.
- `start` while `busy`: ignored.
- `hi_we`/`lo_we`:
  - In IDLE: write HI/LO at the next edge.
  - While `busy`: ignored; the pipeline stalls such instructions.
- `flush` in RUN or FIX: the state returns to IDLE next edge, HI/LO are unchanged and `done` stays 0. `flush` also blocks a same-cycle start.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. Reset mid-operation discards the operation.
- Start accepted at edge k:
  - `busy`=1 from after edge k through the cycle before edge k+XLEN+1;
  - HI/LO are updated at edge k+XLEN+1, with `done`=1 in the cycle that follows;
  - total latency is XLEN+1 cycles (33 for XLEN=32).
- `busy` and `done` are registered.
- A new start may be accepted in the `done` cycle, since the state is then IDLE.

## Configuration
- `MULDIV_DIV_EN` defined: DIV/DIVU are supported as described.
- `MULDIV_DIV_EN` undefined:
  - divide hardware (subtractor, remainder path, divide-by-zero logic) is omitted;
  - op 10/11 is illegal and ignored: no `busy`, HI/LO unchanged, no `done`;
  - MULT/MULTU timing is unchanged.

## Structure
- `muldiv_pkg`: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state encodings (ST_IDLE, ST_RUN, ST_FIX).
- One sub-module, `muldiv_step`: combinational single-iteration datapath (shift-add / shift-subtract), parametrised by XLEN. The FSM, counter, sign handling and HI/LO registers stay in `muldiv_unit`.

## Test plan
All scenarios use XLEN=32.
- MULT a=−3 (FFFFFFFD), b=5 → after 33 cycles: hi=FFFFFFFF, lo=FFFFFFF1; `done` pulses once; `busy` is high for exactly 33 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIVU 100/7 → lo=0000000E, hi=00000002. DIV −7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIV 5/0 → lo=FFFFFFFF, hi=00000005 after 33 cycles. DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- Preload via mthi=1234, mtlo=5678. Start MULT, assert `flush` 10 cycles later → `busy`=0 next cycle, no `done`, hi=1234, lo=5678. A start or mthi issued during the run is ignored.
- rst_n=0 mid-RUN → next cycle busy=0, hi=lo=0. With `MULDIV_DIV_EN` undefined, DIVU 100/7 → busy stays 0 and hi/lo are unchanged.
